multi_level_counter: RTL and testbench

//  Next-generation level/edge event counter: N_CH independent channels, each counting either

---
 rtl/level_counter_pkg.sv | 26 ++
 rtl/level_channel.sv | 59 +++++
 rtl/multi_level_counter.sv | 65 ++++++
 tb/tb_multi_level_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/level_counter_pkg.sv
// Shared types and the per-channel increment decode for the multi-level event counter.
package level_counter_pkg;

  typedef enum logic [1:0] {
    LEVEL = 2'b00,
    RISE  = 2'b01,
    FALL  = 2'b10,
    BOTH  = 2'b11
  } mode_e;

  // Edge modes need one valid prior sample, so they stay silent until primed.
  function automatic logic inc_decode(input mode_e m, input logic cur, input logic smp,
                                      input logic primed);
    logic inc;
    inc = 1'b0;
    case (m)
      LEVEL:   inc = cur;
      RISE:    inc = primed & cur & ~smp;
      FALL:    inc = primed & ~cur & smp;
      BOTH:    inc = primed & (cur ^ smp);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/level_channel.sv
// One counting channel: input synchronizer, tick-rate sample, mode decode, counter and sticky ovf.
module level_channel
  import level_counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lv_in,
  input  mode_e            mode,
  input  logic             sat_en,
  input  logic             clr,
  input  logic             tick,
  input  logic             primed,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   smp_reg;
  logic [WIDTH-1:0]       count_reg;
  logic                   ovf_reg;
  logic                   lv_s;
  logic                   inc;

  assign lv_s = sync_reg[SYNC_STAGES-1];
  assign inc  = inc_decode(mode, lv_s, smp_reg, primed);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg  <= '0;
      smp_reg   <= 1'b0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], lv_in};
      // The sample tracks in every mode so a mode switch never sees a stale history.
      if (tick) smp_reg <= lv_s;
      if (clr) begin
        count_reg <= '0;
        ovf_reg   <= 1'b0;
      end else if (tick && inc) begin
        if (count_reg == CNT_MAX) begin
          ovf_reg <= 1'b1;
          if (!sat_en) count_reg <= '0;
        end else begin
          count_reg <= count_reg + WIDTH'(1);
        end
      end
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/multi_level_counter.sv
// N_CH-channel level/edge event counter sampled on a shared slow tick enable.
module multi_level_counter
  import level_counter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 8,
  parameter int TICK_MAX    = 33000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic [N_CH-1:0]       lv_in,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       sat_en,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       ovf,
  output logic                  tick
);

  localparam int TICK_W = $clog2(TICK_MAX);
  localparam logic [TICK_W-1:0] TCNT_LAST = TICK_W'(TICK_MAX - 1);

  logic [TICK_W-1:0] tcnt_reg;
  logic              primed_reg;
  logic              tick_now;

  // Decoded straight from the counter register, so it is a clean one-cycle strobe.
  assign tick_now = (tcnt_reg == TCNT_LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      tcnt_reg   <= '0;
      primed_reg <= 1'b0;
    end else if (tick_now) begin
      tcnt_reg   <= '0;
      primed_reg <= 1'b1;
    end else begin
      tcnt_reg <= tcnt_reg + TICK_W'(1);
    end
  end

  assign tick = tick_now;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      level_channel #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
        .clk    (CLK100MHZ),
        .reset  (reset),
        .lv_in  (lv_in[gi]),
        .mode   (mode_e'(mode[2*gi +: 2])),
        .sat_en (sat_en[gi]),
        .clr    (clr[gi]),
        .tick   (tick_now),
        .primed (primed_reg),
        .count  (count[WIDTH*gi +: WIDTH]),
        .ovf    (ovf[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_level_counter.sv
// Bench for multi_level_counter: directed vector table, hand sequences and random stimulus vs a model.
module tb_multi_level_counter;
  import level_counter_pkg::*;

  localparam int N_CH     = 4;
  localparam int WIDTH    = 3;
  localparam int TICK_MAX = 4;
  localparam int SYNC     = 2;
  localparam int MAXC     = (1 << WIDTH) - 1;
  localparam logic [2*N_CH-1:0] MD = 8'hB4;  // ch0 LEVEL, ch1 RISE, ch2 BOTH, ch3 FALL

  logic                  clk    = 1'b0;
  logic                  reset  = 1'b0;
  logic [N_CH-1:0]       lv_in  = '0;
  logic [2*N_CH-1:0]     mode   = '0;
  logic [N_CH-1:0]       sat_en = '0;
  logic [N_CH-1:0]       clr    = '0;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       ovf;
  logic                  tick;

  always #5 clk = ~clk;

  multi_level_counter #(
    .N_CH(N_CH), .WIDTH(WIDTH), .TICK_MAX(TICK_MAX), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK100MHZ(clk), .reset(reset), .lv_in(lv_in), .mode(mode), .sat_en(sat_en),
    .clr(clr), .count(count), .ovf(ovf), .tick(tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: integer counts, a delay line for the synchronizer, a phase counter for the tick.
  int              m_cnt[N_CH];
  bit              m_ovf[N_CH];
  bit              m_smp[N_CH];
  bit              m_primed;
  int              m_phase;
  bit              m_tick_edge;
  logic [N_CH-1:0] m_hist[SYNC];

  typedef struct {
    logic [N_CH-1:0]       lv;
    logic [2*N_CH-1:0]     md;
    logic [N_CH-1:0]       sat;
    int                    ticks;
    logic [N_CH*WIDTH-1:0] exp_count;
    logic [N_CH-1:0]       exp_ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH*WIDTH-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [N_CH*WIDTH-1:0] v;
    v = '0;
    v[0*WIDTH +: WIDTH] = WIDTH'(c0);
    v[1*WIDTH +: WIDTH] = WIDTH'(c1);
    v[2*WIDTH +: WIDTH] = WIDTH'(c2);
    v[3*WIDTH +: WIDTH] = WIDTH'(c3);
    return v;
  endfunction

  function automatic void add_vec(input logic [N_CH-1:0] lv, input logic [N_CH-1:0] sat,
                                  input int ticks, input logic [N_CH*WIDTH-1:0] ec,
                                  input logic [N_CH-1:0] eo);
    vec_t v;
    v.lv = lv; v.md = MD; v.sat = sat; v.ticks = ticks; v.exp_count = ec; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic model_edge();
    logic [N_CH-1:0] lvs;
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_smp[i] = 0;
      end
      m_primed = 0; m_phase = 0; m_tick_edge = 0;
      for (int s = 0; s < SYNC; s++) m_hist[s] = '0;
      return;
    end
    m_tick_edge = (m_phase == TICK_MAX - 1);
    lvs = m_hist[SYNC-1];
    for (int i = 0; i < N_CH; i++) begin
      bit inc;
      mode_e md;
      md = mode_e'(mode[2*i +: 2]);
      case (md)
        LEVEL:   inc = lvs[i];
        RISE:    inc = m_primed && lvs[i] && !m_smp[i];
        FALL:    inc = m_primed && !lvs[i] && m_smp[i];
        default: inc = m_primed && (lvs[i] != m_smp[i]);
      endcase
      if (clr[i]) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (m_tick_edge && inc) begin
        if (m_cnt[i] == MAXC) begin
          m_ovf[i] = 1;
          if (!sat_en[i]) m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (m_tick_edge) m_smp[i] = lvs[i];
    end
    if (m_tick_edge) m_primed = 1;
    m_phase = (m_phase + 1) % TICK_MAX;
    for (int s = SYNC - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
    m_hist[0] = lv_in;
  endtask

  task automatic cycle();
    logic [N_CH*WIDTH-1:0] ec;
    logic [N_CH-1:0]       eo;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    ec = pk(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    for (int i = 0; i < N_CH; i++) eo[i] = m_ovf[i];
    check("model_count", 32'(count), 32'(ec));
    check("model_ovf", 32'(ovf), 32'(eo));
    check("model_tick", 32'(tick), 32'(m_phase == TICK_MAX - 1));
  endtask

  task automatic run_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      cycle();
      if (m_tick_edge) seen++;
    end
  endtask

  // Cycle 1 is the cycle right after reset is released; the first tick must appear in cycle TICK_MAX.
  task automatic wait_first_tick(input string name);
    int cyc;
    cyc = 1;
    while (!tick && cyc < 12) begin
      cycle();
      cyc++;
    end
    check(name, 32'(cyc), 32'(TICK_MAX));
    $display("%s: first tick in cycle %0d", name, cyc);
  endtask

  initial begin
    add_vec(4'hF, 4'h0, 1, pk(1, 0, 0, 0), 4'b0000);
    add_vec(4'hF, 4'h0, 2, pk(3, 0, 0, 0), 4'b0000);
    add_vec(4'hF, 4'h0, 4, pk(7, 0, 0, 0), 4'b0000);
    add_vec(4'hF, 4'h0, 1, pk(0, 0, 0, 0), 4'b0001);
    add_vec(4'hF, 4'h0, 1, pk(1, 0, 0, 0), 4'b0001);
    for (int p = 0; p < 10; p++) begin
      add_vec(4'b1100, 4'b0010, 2, pk(1, (p > MAXC) ? MAXC : p, 0, 0),
              {2'b00, p >= MAXC + 1, 1'b1});
      add_vec(4'b1110, 4'b0010, 2, pk(1, (p + 1 > MAXC) ? MAXC : p + 1, 0, 0),
              {2'b00, p + 1 >= MAXC + 1, 1'b1});
    end
    for (int k = 0; k < 3; k++) begin
      add_vec(4'b1010, 4'b0010, 2, pk(1, MAXC, 2*k + 1, 0), 4'b0011);
      add_vec(4'b1110, 4'b0010, 2, pk(1, MAXC, 2*k + 2, 0), 4'b0011);
    end

    // Reset with every input held high.
    reset = 1'b0; lv_in = 4'hF; mode = MD; sat_en = '0; clr = '0;
    repeat (3) cycle();
    check("reset_count", 32'(count), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_tick", 32'(tick), 0);
    reset = 1'b1;
    wait_first_tick("first_tick");

    foreach (vecs[r]) begin
      lv_in = vecs[r].lv; mode = vecs[r].md; sat_en = vecs[r].sat;
      run_ticks(vecs[r].ticks);
      check("row_count", 32'(count), 32'(vecs[r].exp_count));
      check("row_ovf", 32'(ovf), 32'(vecs[r].exp_ovf));
      $display("row %0d lv=%b sat=%b ticks=%0d count=%h ovf=%b", r, vecs[r].lv, vecs[r].sat,
               vecs[r].ticks, count, ovf);
    end

    // Two-cycle low pulse on ch2 placed so neither tick ever samples it.
    cycle(); cycle();
    lv_in[2] = 1'b0;
    cycle(); cycle();
    lv_in[2] = 1'b1;
    run_ticks(1);
    check("short_pulse_ch2", 32'(count[2*WIDTH +: WIDTH]), 6);
    $display("short pulse: count=%h", count);

    // Give ch3 one fall, then clear it on the very tick that carries a second fall.
    lv_in[3] = 1'b0;
    run_ticks(2);
    check("fall_ch3", 32'(count[3*WIDTH +: WIDTH]), 1);
    lv_in[3] = 1'b1;
    run_ticks(2);
    lv_in[3] = 1'b0;
    cycle(); cycle(); cycle();
    check("clr_on_tick_cycle", 32'(tick), 1);
    clr = 4'b1000;
    cycle();
    clr = '0;
    check("clr_count", 32'(count), 32'(pk(1, MAXC, 6, 0)));
    check("clr_ovf", 32'(ovf), 32'b0011);
    $display("clear on tick: count=%h ovf=%b", count, ovf);

    // Reset in the middle of a run with nonzero counts.
    reset = 1'b0;
    cycle();
    check("midreset_count", 32'(count), 0);
    check("midreset_ovf", 32'(ovf), 0);
    check("midreset_tick", 32'(tick), 0);
    reset = 1'b1;
    wait_first_tick("resume_tick");

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) lv_in = N_CH'($urandom);
      if ($urandom_range(0, 40) == 0) mode = (2*N_CH)'($urandom);
      if ($urandom_range(0, 40) == 0) sat_en = N_CH'($urandom);
      clr   = ($urandom_range(0, 30) == 0) ? N_CH'($urandom) : '0;
      reset = ($urandom_range(0, 250) != 0);
      cycle();
      if (n % 100 == 99) $display("random %0d: count=%h ovf=%b", n + 1, count, ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
